// File: rtl/relu_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency ReLU among NREQ requesters.
// In-flight words are tracked by a tag shift register; results land in a credit-protected FIFO.
module relu_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [DW-1:0]       relu_x,
  input  logic [DW-1:0]       relu_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IDW-1:0]      out_id,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH + LAT + 2);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0] last;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic           issue_ok;
  logic           handshake;
  logic           push;
  logic           pop;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  count;
  logic [LAT:0]   tag_valid;
  logic [IDW-1:0] tag_id [LAT+1];
  logic [DW-1:0]  mem_data [DEPTH];
  logic [IDW-1:0] mem_id [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Search starts just after the last granted requester and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[(int'(last) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant       = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) begin
      inflight = inflight + {{(CW-1){1'b0}}, tag_valid[k]};
    end
  end

  // Credits cover both pipeline and FIFO, so a push can never find the FIFO full.
  assign issue_ok  = (inflight + count) < CW'(DEPTH);
  assign handshake = grant_found & issue_ok;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      last      <= IDW'(NREQ - 1);
      relu_x    <= '0;
      tag_valid <= '0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
    end else begin
      if (handshake) last <= grant;
      relu_x    <= handshake ? req_data[int'(grant)*DW +: DW] : '0;
      tag_valid <= {tag_valid[LAT-1:0], handshake};
      tag_id[0] <= grant;
      for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  assign push = tag_valid[LAT];
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= relu_y;
      mem_id[wr_ptr]   <= tag_id[LAT];
    end
  end

  // Head is gated so nothing stale is visible while the FIFO is empty.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_id    = out_valid ? mem_id[rd_ptr] : '0;
  assign busy      = (inflight != '0) | (count != '0);

  push_while_full: assert property (@(posedge clock) disable iff (!resetn)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_relu_rr_scheduler.sv
// Randomized bench for relu_rr_scheduler: a queue-based reference model predicts grants,
// and a scoreboard checks every result word, its id and its arrival cycle.
module tb_relu_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic               clock = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      relu_x;
  logic [DW-1:0]      relu_y;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               busy;

  always #5 clock = ~clock;

  relu_rr_scheduler #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .relu_x(relu_x), .relu_y(relu_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .busy(busy)
  );

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  // External ReLU: LAT registers, sharing the scheduler's reset
  logic [DW-1:0] relu_pipe [LAT];
  always @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < LAT; k++) relu_pipe[k] <= '0;
    end else begin
      relu_pipe[0] <= relu_ref(relu_x);
      for (int k = 1; k < LAT; k++) relu_pipe[k] <= relu_pipe[k-1];
    end
  end
  assign relu_y = relu_pipe[LAT-1];

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    int             due;
  } exp_t;

  exp_t           sb_q [$];
  logic [DW-1:0]  src_q [NREQ][$];
  int             n_pass = 0;
  int             n_total = 0;
  int             cyc = 0;
  int             outstanding = 0;
  int             m_last = NREQ - 1;
  int             m_id = 0;
  int             sel;
  int             wait2 = 0;
  logic           m_hs = 1'b0;
  logic           m_pop = 1'b0;
  logic           exp_valid;
  logic           fair_phase = 1'b0;
  logic [DW-1:0]  m_data;
  logic [DW-1:0]  exp_x = '0;
  logic [NREQ-1:0] exp_ready;
  logic [NREQ-1:0] en = '0;
  logic           drv_resetn = 1'b0;
  logic           drv_out_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model side: predict grant, relu_x, busy and FIFO head between edges
  always @(negedge clock) begin
    if (cyc > 0) begin
      exp_ready = '0;
      m_hs      = 1'b0;
      m_id      = 0;
      if (outstanding < DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          sel = (m_last + k) % NREQ;
          if (!m_hs && req_valid[sel]) begin
            m_hs           = 1'b1;
            m_id           = sel;
            exp_ready[sel] = 1'b1;
          end
        end
      end
      m_data = req_data[m_id*DW +: DW];
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("relu_x", relu_x, exp_x);
      checkOutput("busy", busy, outstanding != 0);
      exp_valid = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
      checkOutput("out_valid", out_valid, exp_valid);
      if (exp_valid && out_valid) begin
        checkOutput("out_data", out_data, sb_q[0].data);
        checkOutput("out_id", out_id, sb_q[0].id);
      end
      m_pop = exp_valid && out_ready;
      if (fair_phase && req_valid[2]) begin
        if (req_ready[2]) begin
          checkOutput("req2_wait_within_nreq", wait2 < NREQ, 1);
          wait2 = 0;
        end else begin
          wait2++;
        end
      end else begin
        wait2 = 0;
      end
    end
  end

  // Model side: commit handshakes and pops at the clock edge
  always @(posedge clock) begin
    cyc++;
    if (!resetn) begin
      sb_q.delete();
      outstanding = 0;
      m_last      = NREQ - 1;
      exp_x       = '0;
    end else begin
      if (m_pop) begin
        void'(sb_q.pop_front());
        outstanding--;
      end
      if (m_hs) begin
        sb_q.push_back('{relu_ref(m_data), IDW'(m_id), cyc + LAT + 1});
        outstanding++;
        m_last = m_id;
        void'(src_q[m_id].pop_front());
      end
      exp_x = m_hs ? m_data : '0;
    end
  end

  task automatic applyStimulus();
    @(posedge clock);
    #1;
    resetn    = drv_resetn;
    out_ready = drv_out_ready;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = en[i] && (src_q[i].size() > 0);
      req_data[i*DW +: DW]    = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic all_idle();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b0;
    return (sb_q.size() == 0) && (outstanding == 0);
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    en            = '1;
    drv_out_ready = 1'b1;
    while (!all_idle() && n < maxc) begin
      applyStimulus();
      n++;
    end
    repeat (2) applyStimulus();
    checkOutput("drain_idle", all_idle(), 1);
  endtask

  initial begin
    resetn    = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) applyStimulus();
    drv_resetn = 1'b1;

    $display("[TB] single requester, positive and negative operand");
    src_q[0].push_back(32'h0000_0005);
    src_q[0].push_back(32'hFFFF_FFFB);
    en = 4'b0001;
    drv_out_ready = 1'b1;
    drain(100);

    $display("[TB] boundary operands on requester 1");
    src_q[1].push_back(32'h8000_0000);
    src_q[1].push_back(32'h7FFF_FFFF);
    src_q[1].push_back(32'h0000_0000);
    en = 4'b0010;
    drain(100);

    $display("[TB] all requesters, consumer always ready");
    for (int i = 0; i < NREQ; i++) repeat (6) src_q[i].push_back(rand_word());
    drain(200);

    $display("[TB] all requesters, consumer stalled then released");
    for (int i = 0; i < NREQ; i++) repeat (3) src_q[i].push_back(rand_word());
    en = '1;
    drv_out_ready = 1'b0;
    repeat (12) applyStimulus();
    drain(200);

    $display("[TB] fairness with late requester 2");
    repeat (20) src_q[1].push_back(rand_word());
    repeat (20) src_q[3].push_back(rand_word());
    en = 4'b1010;
    drv_out_ready = 1'b1;
    repeat (7) applyStimulus();
    repeat (3) src_q[2].push_back(rand_word());
    en = 4'b1110;
    fair_phase = 1'b1;
    repeat (20) applyStimulus();
    fair_phase = 1'b0;
    drain(200);

    $display("[TB] reset with words in flight and buffered");
    for (int i = 0; i < NREQ; i++) repeat (3) src_q[i].push_back(rand_word());
    en = '1;
    drv_out_ready = 1'b0;
    repeat (5) applyStimulus();
    drv_resetn = 1'b0;
    applyStimulus();
    drv_resetn = 1'b1;
    en = 4'b1100;
    repeat (6) applyStimulus();
    drain(200);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (src_q[i].size() < 2 && $urandom_range(0, 3) == 0) src_q[i].push_back(rand_word());
      if (c % 16 == 0) en = NREQ'($urandom);
      drv_out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
